// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and defaults for the camera capture front end
package video_pkg;

  typedef enum logic [1:0] {
    WAIT_VS,
    VBLANK,
    ACTIVE
  } cap_state_t;

  localparam int RGB565_W     = 16;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;

endpackage

// File: rtl/camera_pixel_packer_if.sv
// rtl/camera_pixel_packer_if.sv - camera byte stream in, RGB565 pixel stream out
interface camera_pixel_packer_if;
  import video_pkg::*;

  logic                cam_vsync;
  logic                cam_href;
  logic                cam_byte_en;
  logic [7:0]          cam_data;
  logic [RGB565_W-1:0] pixel_out;
  logic                pixel_valid;
  logic                frame_sync;

  modport master (
    output cam_vsync, cam_href, cam_byte_en, cam_data,
    input  pixel_out, pixel_valid, frame_sync
  );

  modport slave (
    input  cam_vsync, cam_href, cam_byte_en, cam_data,
    output pixel_out, pixel_valid, frame_sync
  );

endinterface

// File: rtl/camera_pixel_packer_sync_edge_detect.sv
// rtl/camera_pixel_packer_sync_edge_detect.sv - rise/fall pulses against the prior registered sample
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;
  assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/camera_pixel_packer.sv
// rtl/camera_pixel_packer.sv - packs VSYNC/HREF byte stream into RGB565 pixels with frame/line status
module camera_pixel_packer
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic                  clk,
  input  logic                  reset,
  camera_pixel_packer_if.slave  cam,
  output logic [9:0]            x_count,
  output logic [9:0]            y_count,
  output logic                  line_end,
  output logic                  frame_done,
  output logic                  err_line_len,
  output logic [7:0]            frame_count
);

  localparam logic [9:0]  H_LIM      = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
  localparam logic [10:0] LINE_BYTES = 11'(2 * H_ACTIVE);

  logic vs_rise, vs_fall, hr_rise, hr_fall;

  sync_edge_detect u_vs_edge (
    .clk(clk), .reset(reset), .sig_i(cam.cam_vsync), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  sync_edge_detect u_hr_edge (
    .clk(clk), .reset(reset), .sig_i(cam.cam_href), .rise_o(hr_rise), .fall_o(hr_fall)
  );

  cap_state_t          state_q, state_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic [10:0]         bcnt_q, bcnt_d;
  logic [9:0]          pcnt_q, pcnt_d;
  logic [RGB565_W-1:0] pix_q, pix_d;
  logic                pv_q, pv_d;
  logic                fs_q, fs_d;
  logic                le_q, le_d;
  logic                fd_q, fd_d;
  logic                err_q, err_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic [7:0]          fc_q, fc_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    bcnt_d  = bcnt_q;
    pcnt_d  = pcnt_q;
    pix_d   = pix_q;
    pv_d    = 1'b0;
    fs_d    = 1'b0;
    le_d    = 1'b0;
    fd_d    = 1'b0;
    err_d   = err_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;

    case (state_q)
      WAIT_VS: begin
        if (cam.cam_vsync) state_d = VBLANK;
      end
      VBLANK: begin
        if (vs_fall) begin
          state_d = ACTIVE;
          fs_d    = 1'b1;
          phase_d = 1'b0;
          bcnt_d  = '0;
          pcnt_d  = '0;
          err_d   = 1'b0;
          x_d     = '0;
          y_d     = '0;
          fc_d    = fc_q + 8'd1;
        end
      end
      ACTIVE: begin
        // a byte arriving with the VSYNC rise belongs to the aborted line
        if (cam.cam_href && cam.cam_byte_en && !vs_rise) begin
          if (bcnt_q != '1) bcnt_d = bcnt_q + 11'd1;
          if (!phase_q) begin
            hi_d    = cam.cam_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pcnt_q != '1) pcnt_d = pcnt_q + 10'd1;
            if (pcnt_q < H_LIM && y_q < V_LIM) begin
              pix_d = {hi_q, cam.cam_data};
              pv_d  = 1'b1;
              x_d   = pcnt_q;
            end
          end
        end
        if (hr_fall) begin
          le_d    = 1'b1;
          if (bcnt_q != LINE_BYTES) err_d = 1'b1;
          phase_d = 1'b0;
          bcnt_d  = '0;
          pcnt_d  = '0;
          x_d     = '0;
          if (y_q != '1) y_d = y_q + 10'd1;
        end
        if (vs_rise) begin
          state_d = VBLANK;
          fd_d    = 1'b1;
          phase_d = 1'b0;
          bcnt_d  = '0;
          pcnt_d  = '0;
          x_d     = '0;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_VS;
      phase_q <= 1'b0;
      hi_q    <= '0;
      bcnt_q  <= '0;
      pcnt_q  <= '0;
      pix_q   <= '0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      le_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      bcnt_q  <= bcnt_d;
      pcnt_q  <= pcnt_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      le_q    <= le_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
    end
  end

  assign cam.pixel_out   = pix_q;
  assign cam.pixel_valid = pv_q;
  assign cam.frame_sync  = fs_q;
  assign x_count         = x_q;
  assign y_count         = y_q;
  assign line_end        = le_q;
  assign frame_done      = fd_q;
  assign err_line_len    = err_q;
  assign frame_count     = fc_q;

  logic unused_ok;
  assign unused_ok = hr_rise;

endmodule

// File: tb/tb_camera_pixel_packer.sv
// tb/tb_camera_pixel_packer.sv - directed bench for camera_pixel_packer
module tb_camera_pixel_packer;
  import video_pkg::*;

  localparam int H = 320;
  localparam int V = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_count, y_count;
  logic       line_end, frame_done, err_line_len;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  camera_pixel_packer_if cam_if ();

  camera_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .cam(cam_if),
    .x_count(x_count), .y_count(y_count), .line_end(line_end),
    .frame_done(frame_done), .err_line_len(err_line_len), .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  // monitor-owned observation state
  logic [15:0] obs_pix[$];
  logic [9:0]  obs_x[$];
  int          n_fs = 0, n_le = 0, n_fd = 0;

  always @(negedge clk) begin
    if (cam_if.pixel_valid) begin
      obs_pix.push_back(cam_if.pixel_out);
      obs_x.push_back(x_count);
    end
    if (cam_if.frame_sync) n_fs++;
    if (line_end)          n_le++;
    if (frame_done)        n_fd++;
  end

  // stimulus-owned expectation state
  logic [15:0] exp_pix[$];
  logic [9:0]  exp_x[$];
  int          rd_idx = 0;
  int          b_pix, b_fs, b_le, b_fd;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] bval(logic [7:0] base, int i);
    return base + 8'(i * 34);
  endfunction

  task automatic mark();
    b_pix = obs_pix.size();
    b_fs  = n_fs;
    b_le  = n_le;
    b_fd  = n_fd;
  endtask

  task automatic set_vs(logic v);
    cam_if.cam_vsync = v;
    tick(4);
  endtask

  task automatic send_byte(logic [7:0] b);
    cam_if.cam_data    = b;
    cam_if.cam_byte_en = 1'b1;
    tick();
    cam_if.cam_byte_en = 1'b0;
    tick();
  endtask

  task automatic send_line(int nbytes, logic [7:0] base, bit cap);
    logic [7:0] prev;
    prev = '0;
    cam_if.cam_href = 1'b1;
    tick(2);
    for (int i = 0; i < nbytes; i++) begin
      if (i % 2 == 1 && cap && i / 2 < H) begin
        exp_pix.push_back({prev, bval(base, i)});
        exp_x.push_back(10'(i / 2));
      end
      prev = bval(base, i);
      send_byte(prev);
    end
    cam_if.cam_href = 1'b0;
    tick(4);
  endtask

  task automatic compare_pixels(string tag);
    check_eq({tag, "_total_pixels"}, 32'(obs_pix.size()), 32'(exp_pix.size()));
    while (rd_idx < obs_pix.size() && rd_idx < exp_pix.size()) begin
      check_eq({tag, "_pixel_out"}, 32'(obs_pix[rd_idx]), 32'(exp_pix[rd_idx]));
      check_eq({tag, "_x_count"}, 32'(obs_x[rd_idx]), 32'(exp_x[rd_idx]));
      rd_idx++;
    end
  endtask

  initial begin
    reset              = 1'b1;
    cam_if.cam_vsync   = 1'b0;
    cam_if.cam_href    = 1'b0;
    cam_if.cam_byte_en = 1'b0;
    cam_if.cam_data    = '0;
    tick(3);

    check_eq("rst_pixel_out", 32'(cam_if.pixel_out), 32'h0);
    check_eq("rst_pixel_valid", 32'(cam_if.pixel_valid), 32'h0);
    check_eq("rst_frame_sync", 32'(cam_if.frame_sync), 32'h0);
    check_eq("rst_line_end", 32'(line_end), 32'h0);
    check_eq("rst_frame_done", 32'(frame_done), 32'h0);
    check_eq("rst_err", 32'(err_line_len), 32'h0);
    check_eq("rst_x", 32'(x_count), 32'h0);
    check_eq("rst_y", 32'(y_count), 32'h0);
    check_eq("rst_frame_count", 32'(frame_count), 32'h0);

    reset = 1'b0;
    tick(2);

    // first frame, first line
    mark();
    set_vs(1'b1);
    set_vs(1'b0);
    check_eq("f1_frame_sync", 32'(n_fs - b_fs), 32'd1);
    send_line(640, 8'h12, 1'b1);
    check_eq("f1_first_pix", 32'(obs_pix.size() > 0 ? obs_pix[0] : 16'h0), 32'h1234);
    check_eq("f1_line_pix", 32'(obs_pix.size() - b_pix), 32'd320);
    check_eq("f1_line_end", 32'(n_le - b_le), 32'd1);
    check_eq("f1_err", 32'(err_line_len), 32'h0);
    check_eq("f1_y_after_line", 32'(y_count), 32'd1);
    check_eq("f1_x_idle", 32'(x_count), 32'd0);

    // rest of the frame, then VSYNC rise
    for (int l = 1; l < V; l++) send_line(640, 8'(l * 16), 1'b1);
    set_vs(1'b1);
    check_eq("f1_frame_pix", 32'(obs_pix.size() - b_pix), 32'(H * V));
    check_eq("f1_y_end", 32'(y_count), 32'(V));
    check_eq("f1_frame_done", 32'(n_fd - b_fd), 32'd1);
    check_eq("f1_frame_count", 32'(frame_count), 32'd1);
    check_eq("f1_line_ends", 32'(n_le - b_le), 32'(V));
    compare_pixels("f1");

    // 641-byte line: sticky error until next frame_sync
    mark();
    set_vs(1'b0);
    check_eq("f2_frame_count", 32'(frame_count), 32'd2);
    send_line(641, 8'h55, 1'b1);
    check_eq("f2_long_pix", 32'(obs_pix.size() - b_pix), 32'd320);
    check_eq("f2_err_set", 32'(err_line_len), 32'h1);
    send_line(640, 8'h66, 1'b1);
    check_eq("f2_err_sticky", 32'(err_line_len), 32'h1);
    set_vs(1'b1);
    check_eq("f2_err_vblank", 32'(err_line_len), 32'h1);
    set_vs(1'b0);
    check_eq("f3_err_cleared", 32'(err_line_len), 32'h0);
    check_eq("f3_frame_count", 32'(frame_count), 32'd3);
    compare_pixels("f2");

    // 700-byte line plus excess lines
    mark();
    send_line(700, 8'h77, 1'b1);
    check_eq("f3_700_pix", 32'(obs_pix.size() - b_pix), 32'd320);
    check_eq("f3_700_err", 32'(err_line_len), 32'h1);
    for (int l = 1; l < V + 2; l++) send_line(640, 8'(8'h80 + l), l < V);
    check_eq("f3_frame_pix", 32'(obs_pix.size() - b_pix), 32'(H * V));
    check_eq("f3_y_end", 32'(y_count), 32'(V + 2));
    check_eq("f3_line_ends", 32'(n_le - b_le), 32'(V + 2));
    check_eq("f3_err_end", 32'(err_line_len), 32'h1);
    set_vs(1'b1);
    compare_pixels("f3");

    // VSYNC rises mid-line after 3 bytes
    mark();
    set_vs(1'b0);
    cam_if.cam_href = 1'b1;
    tick(2);
    exp_pix.push_back(16'h0102);
    exp_x.push_back(10'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    cam_if.cam_vsync = 1'b1;
    tick(3);
    cam_if.cam_href = 1'b0;
    tick(4);
    check_eq("f4_abort_pix", 32'(obs_pix.size() - b_pix), 32'd1);
    check_eq("f4_abort_done", 32'(n_fd - b_fd), 32'd1);
    check_eq("f4_abort_line_end", 32'(n_le - b_le), 32'd0);
    mark();
    set_vs(1'b0);
    send_line(640, 8'hA0, 1'b1);
    check_eq("f5_first_pix", 32'(obs_pix.size() > b_pix ? obs_pix[b_pix] : 16'h0), 32'hA0C2);
    check_eq("f5_frame_count", 32'(frame_count), 32'd5);
    compare_pixels("f5");

    // reset mid-line, released with VSYNC low and HREF high
    cam_if.cam_href = 1'b1;
    tick(2);
    exp_pix.push_back(16'h1122);
    exp_x.push_back(10'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    tick(2);
    check_eq("mid_rst_frame_count", 32'(frame_count), 32'h0);
    check_eq("mid_rst_y", 32'(y_count), 32'h0);
    check_eq("mid_rst_pixel_out", 32'(cam_if.pixel_out), 32'h0);
    reset = 1'b0;
    mark();
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
    cam_if.cam_href = 1'b0;
    tick(4);
    check_eq("post_rst_no_pix", 32'(obs_pix.size() - b_pix), 32'd0);
    check_eq("post_rst_no_fs", 32'(n_fs - b_fs), 32'd0);
    check_eq("post_rst_no_le", 32'(n_le - b_le), 32'd0);
    set_vs(1'b1);
    set_vs(1'b0);
    check_eq("post_rst_fs", 32'(n_fs - b_fs), 32'd1);
    check_eq("post_rst_frame_count", 32'(frame_count), 32'd1);
    send_line(640, 8'h31, 1'b1);
    check_eq("post_rst_line_pix", 32'(obs_pix.size() - b_pix), 32'd320);
    compare_pixels("rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/camera_pixel_packer.md
# camera_pixel_packer

Capture-front-end stage that turns the synchronized OV7670-style byte stream (VSYNC/HREF/8-bit data) into RGB565 pixels, one `pixel_valid` strobe per pixel. It sits directly upstream of the video scrambler. It drives the scrambler's `pixel_in` from `pixel_out`, its `enable` from `pixel_valid`, and its `frame_sync` from `frame_sync`. It also reports line/frame geometry and framing errors to the control logic.

## Interface
- `H_ACTIVE`, 320, pixels per active line accepted.
- `V_ACTIVE`, 240, active lines per frame accepted.
- `clk`  in  1  system clock; the single clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `cam_vsync`  in  1  camera VSYNC, already synchronized to `clk`; high = vertical blanking.
- `cam_href`  in  1  camera HREF, synchronized; high = active line bytes.
- `cam_byte_en`  in  1  one-cycle strobe per camera byte (PCLK edge, synchronized).
- `cam_data`  in  8  camera byte, valid when `cam_byte_en`.
- `pixel_out`  out  16  RGB565 pixel, {first byte, second byte}.
- `pixel_valid`  out  1  one-cycle strobe, `pixel_out` valid.
- `frame_sync`  out  1  one-cycle pulse at start of each captured frame.
- `x_count`  out  10  index of the pixel on `pixel_out`.
- `y_count`  out  10  index of the current line.
- `line_end`  out  1  one-cycle pulse when HREF falls in ACTIVE.
- `frame_done`  out  1  one-cycle pulse when VSYNC rises in ACTIVE.
- `err_line_len`  out  1  sticky; a line in this frame had a byte count ≠ 2·H_ACTIVE; cleared at `frame_sync`.
- `frame_count`  out  8  captured frames, wraps 255→0.

## Operation
- Registered samples `vsync_d`, `href_d` provide edge detection. Edges compare the current input against the prior sample.
- FSM states:
  - WAIT_VS: entered after reset. Go to VBLANK on `cam_vsync`=1. Partial frames after reset are never captured.
  - VBLANK: on VSYNC falling edge, go to ACTIVE and pulse `frame_sync`. Also clear `y_count`, `x_count`, byte phase and `err_line_len`, and increment `frame_count`.
  - ACTIVE: capture pixels. On VSYNC rising edge, pulse `frame_done` and go to VBLANK. Any line in progress is aborted, and its half pixel is discarded.
- Byte packing happens in ACTIVE when `cam_href`=1 and `cam_byte_en`=1:
  - Phase 0 latches the high byte.
  - Phase 1 forms the pixel and toggles the phase back.
  - `cam_byte_en` with `cam_href`=0 is ignored.
- A pixel is emitted (`pixel_valid`) only if `x_count` < H_ACTIVE and `y_count` < V_ACTIVE. Excess pixels/lines are dropped silently but still counted for the length check.
- On HREF falling edge in ACTIVE:
  - pulse `line_end`;
  - set `err_line_len` if bytes in line ≠ 2·H_ACTIVE (an odd count included);
  - reset byte phase and the line pixel counter;
  - increment `y_count`, saturating at 1023.
- `x_count` holds the index of the last emitted pixel (0-based). It is 0 outside active lines.
- Simultaneous events:
  - VSYNC rise with HREF fall in one cycle: `frame_done` wins; `line_end` is still pulsed, and the error check still applies.
  - Byte strobe in the same cycle HREF falls: the byte is ignored, since `cam_href`=0.
- Reset mid-frame: all outputs return to reset values, state goes to WAIT_VS, and `frame_count` is cleared.

## Timing
- Reset values: `pixel_out`=0; `pixel_valid`, `frame_sync`, `line_end`, `frame_done`, `err_line_len` = 0; `x_count`=`y_count`=0; `frame_count`=0.
- Latency:
  - `pixel_valid`/`pixel_out` assert the cycle after the clock edge sampling the second-byte strobe.
  - `frame_sync`, `line_end` and `frame_done` assert the cycle after the sampled edge.
- All outputs are registered; no combinational input→output path.
- No back-pressure: the downstream stage accepts every `pixel_valid`. Pulses are exactly one cycle wide.
- `frame_sync` precedes the first `pixel_valid` of its frame by ≥1 cycle. This ensures the scrambler LFSR is reseeded before pixel 0.

## Structure
- Shared package `video_pkg`: FSM state enum `cap_state_t` {WAIT_VS, VBLANK, ACTIVE}, `RGB565_W`=16, default `H_ACTIVE`/`V_ACTIVE`.
- One natural sub-module, `sync_edge_detect`: per-signal registered rise/fall pulses, instantiated for VSYNC and HREF.
- The rest is a single FSM plus the byte-phase and counter datapath.

## Test plan
- After reset, vsync 1→0, then 1 line of 640 bytes 0x12,0x34,… → `frame_sync` one pulse; first `pixel_out`=0x1234 with `x_count`=0; 320 `pixel_valid`; `line_end` once; `err_line_len`=0.
- Full 240×320 frame, then VSYNC rise → 76 800 pixel strobes; `y_count`=240; `frame_done` one pulse; `frame_count`=1.
- Line of 641 bytes → 320 pixels, last byte dropped, `err_line_len`=1. It stays 1 until the next `frame_sync`, then clears.
- 700-byte line and 250 lines → only 320 pixels/line and 240 lines are emitted; `err_line_len`=1.
- VSYNC rises mid-line after 3 bytes → 1 pixel emitted, the third byte is discarded, `frame_done` pulses, and the next frame's first pixel is formed from its own first two bytes.
- Reset asserted mid-frame, released with VSYNC low and HREF active → no `pixel_valid` until a full VSYNC high→low is seen; `frame_count` restarts at 1.
